// File: rtl/associate_arbiter_pkg.sv
// Shared definitions for the associate_arbiter slice: FSM state encoding,
// channel widths and an index-width helper.
package associate_arbiter_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t ARG  = 3'd1;
  localparam state_t RES  = 3'd2;
  localparam state_t ERR  = 3'd3;
  localparam state_t FBK  = 3'd4;

  localparam int ARG_W = 8;
  localparam int DAT_W = 16;

  // Width of an index into an n-entry vector, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/associate_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared
// associate unit. master = arbiter view, slave = requesters + unit view.
interface associate_arbiter_if
  import associate_arbiter_pkg::*;
#(
  parameter int REQN = 2,
  parameter int ARGN = 2
) ();

  logic [REQN-1:0]             req_arg_stb;
  logic [ARG_W*ARGN*REQN-1:0]  req_arg_dat;
  logic [REQN-1:0]             req_trn;
  logic [REQN-1:0]             req_arg_rdy;
  logic [REQN-1:0]             req_res_stb;
  logic [DAT_W-1:0]            req_res_dat;
  logic [REQN-1:0]             req_res_rdy;
  logic [REQN-1:0]             req_err_stb;
  logic [DAT_W*REQN-1:0]       req_err_dat;
  logic [REQN-1:0]             req_err_rdy;
  logic [REQN-1:0]             req_fbk_stb;
  logic [DAT_W*ARGN-1:0]       req_fbk_dat;
  logic [REQN-1:0]             req_fbk_rdy;
  logic [REQN-1:0]             gnt;

  logic                        arg_stb;
  logic [ARG_W*ARGN-1:0]       arg_dat;
  logic                        arg_rdy;
  logic                        en;
  logic                        res_stb;
  logic [DAT_W-1:0]            res_dat;
  logic                        res_rdy;
  logic                        err_stb;
  logic [DAT_W-1:0]            err_dat;
  logic                        err_rdy;
  logic                        fbk_stb;
  logic [DAT_W*ARGN-1:0]       fbk_dat;
  logic                        fbk_rdy;

  modport master (
    input  req_arg_stb, req_arg_dat, req_trn, req_res_rdy,
    input  req_err_stb, req_err_dat, req_fbk_rdy,
    output req_arg_rdy, req_res_stb, req_res_dat, req_err_rdy,
    output req_fbk_stb, req_fbk_dat, gnt,
    output arg_stb, arg_dat, en, res_rdy, err_stb, err_dat, fbk_rdy,
    input  arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );

  modport slave (
    output req_arg_stb, req_arg_dat, req_trn, req_res_rdy,
    output req_err_stb, req_err_dat, req_fbk_rdy,
    input  req_arg_rdy, req_res_stb, req_res_dat, req_err_rdy,
    input  req_fbk_stb, req_fbk_dat, gnt,
    input  arg_stb, arg_dat, en, res_rdy, err_stb, err_dat, fbk_rdy,
    output arg_rdy, res_stb, res_dat, err_rdy, fbk_stb, fbk_dat
  );

endinterface

// File: rtl/associate_arbiter_rr_pick.sv
// Combinational one-hot pick: first requesting index at or after start,
// wrapping to the lowest requesting index when none lies above start.
module rr_pick
  import associate_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = (IW'(gi) >= start);
  end

  assign masked = req & mask;
  assign src    = (|masked) ? masked : req;
  // Two's-complement trick isolates the lowest set bit.
  assign pick   = src & (~src + N'(1));
  assign any    = |req;

  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (pick[k]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/associate_arbiter.sv
// Round-robin scheduler sharing one associate unit among REQN requesters.
// Define ASSOC_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module associate_arbiter
  import associate_arbiter_pkg::*;
#(
  parameter int REQN = 2,
  parameter int ARGN = 2
) (
  input logic          clk,
  input logic          rst_n,
  associate_arbiter_if.master bus
);

  localparam int IW = idx_w(REQN);
  localparam int AW = ARG_W * ARGN;

  state_t          state_reg, state_next;
  logic [REQN-1:0] gnt_reg;
  logic [IW-1:0]   gidx_reg;
  logic            trn_reg;

  logic [REQN-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   start;

  logic arg_ack, res_ack, err_ack, fbk_ack;

`ifdef ASSOC_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IW-1:0] last_reg;

  assign start = (last_reg == IW'(REQN-1)) ? '0 : last_reg + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= IW'(REQN-1);
    end else if (state_reg == IDLE && pick_any) begin
      last_reg <= pick_idx;
    end
  end
`endif

  rr_pick #(.N(REQN)) u_pick (
    .req   (bus.req_arg_stb),
    .start (start),
    .pick  (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign arg_ack = bus.arg_stb & bus.arg_rdy;
  assign res_ack = bus.res_stb & bus.res_rdy;
  assign err_ack = bus.err_stb & bus.err_rdy;
  assign fbk_ack = bus.fbk_stb & bus.fbk_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      gidx_reg  <= '0;
      trn_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_any) begin
        gnt_reg  <= pick;
        gidx_reg <= pick_idx;
        trn_reg  <= |(bus.req_trn & pick);
      end else if (state_reg != IDLE && state_next == IDLE) begin
        // Clearing here keeps gnt and en at zero throughout IDLE.
        gnt_reg <= '0;
        trn_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (pick_any) state_next = ARG;
      ARG:  if (arg_ack)  state_next = RES;
      RES:  if (res_ack)  state_next = trn_reg ? ERR : IDLE;
      ERR:  if (err_ack)  state_next = FBK;
      FBK:  if (fbk_ack)  state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt         = gnt_reg;
    bus.en          = trn_reg;
    bus.arg_stb     = 1'b0;
    bus.req_arg_rdy = '0;
    bus.req_res_stb = '0;
    bus.res_rdy     = 1'b0;
    bus.err_stb     = 1'b0;
    bus.req_err_rdy = '0;
    bus.req_fbk_stb = '0;
    bus.fbk_rdy     = 1'b0;
    // Data paths are pure muxes; their value only matters while the stb is up.
    bus.arg_dat     = bus.req_arg_dat[gidx_reg*AW +: AW];
    bus.err_dat     = bus.req_err_dat[gidx_reg*DAT_W +: DAT_W];
    bus.req_res_dat = bus.res_dat;
    bus.req_fbk_dat = bus.fbk_dat;
    case (state_reg)
      ARG: begin
        bus.arg_stb     = |(bus.req_arg_stb & gnt_reg);
        bus.req_arg_rdy = gnt_reg & {REQN{bus.arg_rdy}};
      end
      RES: begin
        bus.req_res_stb = gnt_reg & {REQN{bus.res_stb}};
        bus.res_rdy     = |(bus.req_res_rdy & gnt_reg);
      end
      ERR: begin
        bus.err_stb     = |(bus.req_err_stb & gnt_reg);
        bus.req_err_rdy = gnt_reg & {REQN{bus.err_rdy}};
      end
      FBK: begin
        bus.req_fbk_stb = gnt_reg & {REQN{bus.fbk_stb}};
        bus.fbk_rdy     = |(bus.req_fbk_rdy & gnt_reg);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_associate_arbiter.sv
// Scoreboard bench for associate_arbiter: each expected transaction is queued
// when its request is driven and checked as the grant walks through its phases.
module tb_associate_arbiter;
  import associate_arbiter_pkg::*;

  localparam int REQN = 2;
  localparam int ARGN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  associate_arbiter_if #(.REQN(REQN), .ARGN(ARGN)) dut_if ();

  associate_arbiter #(.REQN(REQN), .ARGN(ARGN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.master)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic        trn;
    logic [15:0] arg;
    logic [15:0] res;
    logic [15:0] err;
    logic [31:0] fbk;
    int          hold;
    bit          drop;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int stall_cycles = 0;

  function automatic exp_t mk(input logic [1:0] g, input logic t, input logic [15:0] a,
                              input logic [15:0] r, input logic [15:0] e, input logic [31:0] f,
                              input int hold, input bit drop);
    exp_t x;
    x.gnt = g; x.trn = t; x.arg = a; x.res = r; x.err = e; x.fbk = f;
    x.hold = hold; x.drop = drop;
    return x;
  endfunction

  // Advance one clock; the unit model counts down its post-feedback update.
  task automatic step();
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
  endtask

  // Carries the oldest queued transaction through grant, ARG, RES, ERR, FBK.
  task automatic serve();
    exp_t e;
    int n;
    int g;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: queue empty, expected at least 1 entry");
      return;
    end
    e = sb.pop_front();
    g = (e.gnt == 2'b10) ? 1 : 0;
    dut_if.req_err_dat[g*16 +: 16] = e.err;
    #1;
    tests++;
    if (dut_if.gnt !== 2'b00) begin
      fails++; $display("FAIL idle_gnt: gnt=%b expected 00", dut_if.gnt);
    end
    n = 0;
    do begin step(); n++; end while (dut_if.gnt === 2'b00 && n < 8);
    #1;
    tests++;
    if (n !== 1 || dut_if.gnt !== e.gnt) begin
      fails++; $display("FAIL grant: gnt=%b after %0d cycles, expected %b after 1", dut_if.gnt, n, e.gnt);
    end
    tests++;
    if (dut_if.en !== e.trn) begin
      fails++; $display("FAIL en_grant: en=%b expected %b", dut_if.en, e.trn);
    end
    stall_cycles = 0;
    dut_if.arg_rdy = 1'b0;
    while (busy_cnt > 0 && stall_cycles < 16) begin
      #1;
      tests++;
      if (dut_if.arg_stb !== 1'b1 || dut_if.arg_dat !== e.arg || dut_if.req_arg_rdy !== 2'b00) begin
        fails++;
        $display("FAIL arg_stall: stb=%b dat=%h rdy=%b expected 1 %h 00",
                 dut_if.arg_stb, dut_if.arg_dat, dut_if.req_arg_rdy, e.arg);
      end
      stall_cycles++;
      step();
    end
    dut_if.arg_rdy = 1'b1;
    #1;
    tests++;
    if (dut_if.arg_stb !== 1'b1 || dut_if.arg_dat !== e.arg || dut_if.req_arg_rdy !== e.gnt) begin
      fails++;
      $display("FAIL arg: stb=%b dat=%h rdy=%b expected 1 %h %b",
               dut_if.arg_stb, dut_if.arg_dat, dut_if.req_arg_rdy, e.arg, e.gnt);
    end
    step();
    dut_if.arg_rdy = 1'b0;
    if (e.drop) dut_if.req_arg_stb[g] = 1'b0;
    dut_if.res_stb = 1'b1;
    dut_if.res_dat = e.res;
    dut_if.req_res_rdy = ~e.gnt;
    for (int i = 0; i < e.hold; i++) begin
      #1;
      tests++;
      if (dut_if.res_rdy !== 1'b0 || dut_if.req_res_stb !== e.gnt || dut_if.gnt !== e.gnt) begin
        fails++;
        $display("FAIL res_backpressure: res_rdy=%b req_res_stb=%b gnt=%b expected 0 %b %b",
                 dut_if.res_rdy, dut_if.req_res_stb, dut_if.gnt, e.gnt, e.gnt);
      end
      step();
    end
    dut_if.req_res_rdy = 2'b11;
    #1;
    tests++;
    if (dut_if.req_res_stb !== e.gnt || dut_if.req_res_dat !== e.res || dut_if.res_rdy !== 1'b1) begin
      fails++;
      $display("FAIL res: req_res_stb=%b dat=%h res_rdy=%b expected %b %h 1",
               dut_if.req_res_stb, dut_if.req_res_dat, dut_if.res_rdy, e.gnt, e.res);
    end
    step();
    dut_if.res_stb = 1'b0;
    dut_if.req_res_rdy = 2'b00;
    if (e.trn) begin
      dut_if.req_err_stb[g] = 1'b1;
      dut_if.err_rdy = 1'b1;
      #1;
      tests++;
      if (dut_if.err_stb !== 1'b1 || dut_if.err_dat !== e.err || dut_if.req_err_rdy !== e.gnt ||
          dut_if.en !== 1'b1) begin
        fails++;
        $display("FAIL err: stb=%b dat=%h req_err_rdy=%b en=%b expected 1 %h %b 1",
                 dut_if.err_stb, dut_if.err_dat, dut_if.req_err_rdy, dut_if.en, e.err, e.gnt);
      end
      step();
      dut_if.req_err_stb[g] = 1'b0;
      dut_if.err_rdy = 1'b0;
      dut_if.fbk_stb = 1'b1;
      dut_if.fbk_dat = e.fbk;
      dut_if.req_fbk_rdy = 2'b11;
      #1;
      tests++;
      if (dut_if.req_fbk_stb !== e.gnt || dut_if.req_fbk_dat !== e.fbk || dut_if.fbk_rdy !== 1'b1 ||
          dut_if.en !== 1'b1 || dut_if.req_arg_rdy !== 2'b00 || dut_if.req_res_stb !== 2'b00) begin
        fails++;
        $display("FAIL fbk: req_fbk_stb=%b dat=%h fbk_rdy=%b en=%b expected %b %h 1 1",
                 dut_if.req_fbk_stb, dut_if.req_fbk_dat, dut_if.fbk_rdy, dut_if.en, e.gnt, e.fbk);
      end
      step();
      dut_if.fbk_stb = 1'b0;
      dut_if.req_fbk_rdy = 2'b00;
      busy_cnt = ARGN;
    end
    #1;
    tests++;
    if (dut_if.gnt !== 2'b00 || dut_if.en !== 1'b0) begin
      fails++; $display("FAIL bubble: gnt=%b en=%b expected 00 0", dut_if.gnt, dut_if.en);
    end
    $display("[TB] txn gnt=%b trn=%b arg=%h res=%h stalls=%0d", e.gnt, e.trn, e.arg, e.res, stall_cycles);
  endtask

  task automatic test_reset();
    dut_if.req_arg_stb = 2'b11;
    step(); step();
    tests++;
    if (dut_if.gnt !== 2'b00 || dut_if.en !== 1'b0 || dut_if.arg_stb !== 1'b0 ||
        dut_if.req_arg_rdy !== 2'b00 || dut_if.res_rdy !== 1'b0 || dut_if.err_stb !== 1'b0 ||
        dut_if.fbk_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b en=%b arg_stb=%b req_arg_rdy=%b expected 00 0 0 00",
               dut_if.gnt, dut_if.en, dut_if.arg_stb, dut_if.req_arg_rdy);
    end
    dut_if.req_arg_stb = 2'b00;
    rst_n = 1'b1;
    step();
    $display("[TB] reset state checked");
  endtask

  task automatic test_single();
    dut_if.req_arg_dat[16 +: 16] = 16'h2010;
    dut_if.req_trn = 2'b00;
    dut_if.req_arg_stb = 2'b10;
    sb.push_back(mk(2'b10, 1'b0, 16'h2010, 16'h1234, 16'h0000, 32'h0, 0, 1'b1));
    serve();
  endtask

  task automatic test_round_robin();
    dut_if.req_arg_dat[0 +: 16] = 16'hA1A0;
    dut_if.req_arg_dat[16 +: 16] = 16'hB1B0;
    dut_if.req_trn = 2'b00;
    dut_if.req_arg_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ASSOC_ARB_FIXED_PRIO_EN
      sb.push_back(mk(2'b01, 1'b0, 16'hA1A0, 16'h4000 + 16'(i), 16'h0, 32'h0, 0, 1'b0));
`else
      if (i % 2 == 0) sb.push_back(mk(2'b01, 1'b0, 16'hA1A0, 16'h4000 + 16'(i), 16'h0, 32'h0, 0, 1'b0));
      else            sb.push_back(mk(2'b10, 1'b0, 16'hB1B0, 16'h4000 + 16'(i), 16'h0, 32'h0, 0, 1'b0));
`endif
    end
    for (int i = 0; i < 4; i++) serve();
    dut_if.req_arg_stb = 2'b00;
  endtask

  task automatic test_training();
    dut_if.req_arg_dat[0 +: 16] = 16'h0302;
    dut_if.req_trn = 2'b01;
    dut_if.req_arg_stb = 2'b01;
    sb.push_back(mk(2'b01, 1'b1, 16'h0302, 16'h5555, 16'h0100, 32'hCAFE_0BAD, 0, 1'b1));
    serve();
    dut_if.req_trn = 2'b00;
  endtask

  task automatic test_backpressure();
    dut_if.req_arg_dat[0 +: 16] = 16'h7766;
    dut_if.req_trn = 2'b00;
    dut_if.req_arg_stb = 2'b01;
    sb.push_back(mk(2'b01, 1'b0, 16'h7766, 16'h9ABC, 16'h0, 32'h0, 5, 1'b1));
    serve();
  endtask

  task automatic test_back_to_back();
    dut_if.req_arg_dat[0 +: 16] = 16'h1111;
    dut_if.req_trn = 2'b01;
    dut_if.req_arg_stb = 2'b01;
    sb.push_back(mk(2'b01, 1'b1, 16'h1111, 16'h0AAA, 16'h0200, 32'h1357_2468, 0, 1'b0));
    sb.push_back(mk(2'b01, 1'b1, 16'h1111, 16'h0BBB, 16'h0300, 32'h8642_7531, 0, 1'b1));
    serve();
    serve();
    tests++;
    if (stall_cycles < 1) begin
      fails++; $display("FAIL b2b_stall: %0d stall cycles seen, expected at least 1", stall_cycles);
    end
    dut_if.req_trn = 2'b00;
  endtask

  task automatic test_reset_mid();
    int n;
    dut_if.req_arg_dat[0 +: 16] = 16'h4242;
    dut_if.req_trn = 2'b01;
    dut_if.req_arg_stb = 2'b01;
    busy_cnt = 0;
    n = 0;
    do begin step(); n++; end while (dut_if.gnt === 2'b00 && n < 8);
    dut_if.arg_rdy = 1'b1;
    step();
    dut_if.arg_rdy = 1'b0;
    dut_if.res_stb = 1'b1;
    dut_if.req_res_rdy = 2'b01;
    step();
    dut_if.res_stb = 1'b0;
    dut_if.req_res_rdy = 2'b00;
    dut_if.req_err_stb = 2'b01;
    dut_if.err_rdy = 1'b0;
    #1;
    tests++;
    if (dut_if.err_stb !== 1'b1 || dut_if.gnt !== 2'b01 || dut_if.en !== 1'b1) begin
      fails++;
      $display("FAIL reach_err: err_stb=%b gnt=%b en=%b expected 1 01 1", dut_if.err_stb, dut_if.gnt, dut_if.en);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (dut_if.gnt !== 2'b00 || dut_if.en !== 1'b0 || dut_if.err_stb !== 1'b0 ||
        dut_if.req_err_rdy !== 2'b00 || dut_if.arg_stb !== 1'b0 || dut_if.req_arg_rdy !== 2'b00 ||
        dut_if.res_rdy !== 1'b0 || dut_if.req_res_stb !== 2'b00 || dut_if.fbk_rdy !== 1'b0 ||
        dut_if.req_fbk_stb !== 2'b00) begin
      fails++;
      $display("FAIL async_reset: gnt=%b en=%b err_stb=%b req_err_rdy=%b expected 00 0 0 00",
               dut_if.gnt, dut_if.en, dut_if.err_stb, dut_if.req_err_rdy);
    end
    dut_if.req_err_stb = 2'b00;
    dut_if.req_arg_stb = 2'b00;
    step();
    rst_n = 1'b1;
    busy_cnt = 0;
    dut_if.req_trn = 2'b00;
    dut_if.req_arg_dat[16 +: 16] = 16'h5151;
    dut_if.req_arg_stb = 2'b11;
    sb.push_back(mk(2'b01, 1'b0, 16'h4242, 16'hD00D, 16'h0, 32'h0, 0, 1'b1));
    serve();
    dut_if.req_arg_stb = 2'b00;
  endtask

  initial begin
    dut_if.req_arg_stb = '0; dut_if.req_arg_dat = '0; dut_if.req_trn = '0;
    dut_if.req_res_rdy = '0; dut_if.req_err_stb = '0; dut_if.req_err_dat = '0;
    dut_if.req_fbk_rdy = '0; dut_if.arg_rdy = 1'b0; dut_if.res_stb = 1'b0;
    dut_if.res_dat = '0; dut_if.err_rdy = 1'b0; dut_if.fbk_stb = 1'b0; dut_if.fbk_dat = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_training();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/associate_arbiter.md
# associate_arbiter

Round-robin scheduler that shares one `associate` neuron between `REQN` requesters. It grants the unit to one requester for a complete transaction: argument, result and, when training, error and feedback. It muxes every handshake channel between the granted requester and the unit. It sits between the requester ports of a layer and the `associate` instance, with zero added latency on any data channel.

## Interface
- `REQN`, 2: number of requesters; ≥2.
- `ARGN`, 2: argument count of the shared `associate`; sets the `arg` and `fbk` widths.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_arg_stb` in REQN: per-requester argument strobe.
- `req_arg_dat` in 8*ARGN*REQN: argument vectors; requester r occupies slice `r*8*ARGN +: 8*ARGN`.
- `req_trn` in REQN: train flag, sampled with `req_arg_stb` at grant.
- `req_arg_rdy` out REQN: argument accept.
- `req_res_stb` out REQN, `req_res_dat` out 16 (shared), `req_res_rdy` in REQN: result return.
- `req_err_stb` in REQN, `req_err_dat` in 16*REQN, `req_err_rdy` out REQN: error in.
- `req_fbk_stb` out REQN, `req_fbk_dat` out 16*ARGN (shared), `req_fbk_rdy` in REQN: feedback out.
- `gnt` out REQN: one-hot current grant; zero when idle.
- `arg_stb` out 1, `arg_dat` out 8*ARGN, `arg_rdy` in 1: argument channel to the unit.
- `en` out 1: training enable to the unit.
- `res_stb` in 1, `res_dat` in 16, `res_rdy` out 1: result channel from the unit.
- `err_stb` out 1, `err_dat` out 16, `err_rdy` in 1: error channel to the unit.
- `fbk_stb` in 1, `fbk_dat` in 16*ARGN, `fbk_rdy` out 1: feedback channel from the unit.

## Operation
- States:
  - IDLE: arbitrate.
  - ARG: forward argument.
  - RES: return result.
  - ERR: forward error.
  - FBK: return feedback.
- All channels use a valid/ready handshake; ack = stb & rdy.
- IDLE:
  - If any `req_arg_stb` is high, pick the winner and register `gnt` (one-hot).
  - Latch `trn` = `req_trn[winner]`. Go to ARG.
  - All `req_*_rdy`/`req_*_stb` outputs stay 0.
- Round robin: search starts at index `last+1` mod REQN. `last` is updated at each grant. Reset value of `last` is REQN-1, so requester 0 wins first.
- ARG:
  - `arg_stb` = `req_arg_stb[g]`, `arg_dat` = slice g, `req_arg_rdy[g]` = `arg_rdy`.
  - On ack, go to RES.
- RES:
  - `req_res_stb[g]` = `res_stb`, `res_rdy` = `req_res_rdy[g]`, `req_res_dat` = `res_dat`.
  - On ack, go to ERR if `trn`, else IDLE.
- ERR: mirrors ARG for the err channel. On ack, go to FBK.
- FBK: mirrors RES for the fbk channel. On ack, go to IDLE.
- `en` = latched `trn` throughout a grant. `en` is 0 in IDLE.
- Non-granted requesters see all their rdy/stb outputs at 0. Their requests stay pending, with no drop and no timeout.
- After FBK, the unit spends ARGN cycles updating with `arg_rdy` low. The next ARG simply stalls; no extra logic is needed for this.
- A requester dropping `req_arg_stb` after grant is a protocol violation; the arbiter holds the grant until the ack.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N is forwarded on `arg_stb` in cycle N+1.
- Forwarded channels are combinational through the grant mux; no data registers.
- State return to IDLE occurs on the edge of the final ack. The earliest next grant is that edge+1, so there is a 1-cycle bubble between transactions.
- Reset (any time, including mid-transaction):
  - State goes to IDLE, `gnt`=0, `trn`=0, `last`=REQN-1.
  - All stb/rdy outputs go to 0 and `en`=0.
  - Data outputs are don't-care.
- The arbiter does not drive the unit's own synchronous `rst`. Reset while the unit is busy requires the unit to be reset by the system too.

## Configuration
- `ASSOC_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins every IDLE decision; `last` is not implemented.
  - Undefined (default): round robin as above.

## Structure
- Shared package holds:
  - the state encoding localparams: IDLE=0, ARG=1, RES=2, ERR=3, FBK=4, 3 bits;
  - the channel width constants: ARG_W=8, DAT_W=16.
- One sub-module, `rr_pick`: combinational one-hot pick from a REQN request vector and a start index. It also covers the fixed-priority mode, with start=0.

## Test plan
- Single requester 1, `trn`=0, args 0x10/0x20:
  - `gnt`=0b10 one cycle after the strobe; unit sees those args.
  - Result delivered only on `req_res_stb[1]`; back to IDLE, `en` stays 0.
- Both requesting continuously, `trn`=0:
  - Grants alternate 0,1,0,1 over 4 transactions with a 1-cycle IDLE between.
  - With `ASSOC_ARB_FIXED_PRIO_EN`: 0,0,0,0.
- Requester 0, `trn`=1, err 0x0100:
  - `en`=1 from grant through FBK.
  - `err_dat`=0x0100 reaches the unit; `req_fbk_stb[0]` carries 16*ARGN feedback; requester 1 sees no strobes.
- Backpressure: `req_res_rdy[0]` held low 5 cycles → `res_rdy` stays low, state stays RES, `gnt` unchanged.
- `rst_n` pulsed low during ERR → `gnt`=0, `en`=0, all stb/rdy outputs 0 immediately (asynchronous). The next request from requester 0 wins.
- Back-to-back training transactions → second `arg_stb` holds until unit `arg_rdy` rises after its ARGN update cycles; no lost argument.
